// File: rtl/cpu_reset_seq_pkg.sv
// Shared types for the CPU reset sequencer: sequencer states and reset-cause codes.
package cpu_reset_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HOLD = 2'd1,
        S_REL  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

endpackage

// File: rtl/cpu_reset_seq_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with arst_n, releases on the
// second rising clock edge after arst_n goes high.
module reset_sync (
    input  logic clk,
    input  logic arst_n,
    output logic sync_n
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta   <= 1'b0;
            sync_n <= 1'b0;
        end else begin
            meta   <= 1'b1;
            sync_n <= meta;
        end
    end

endmodule

// File: rtl/cpu_reset_seq.sv
// Reset sequencer: holds NCH active-low channel resets after clrn release or a
// software/watchdog re-reset, then releases them one by one STAGGER cycles apart.
module cpu_reset_seq
    import cpu_reset_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int HOLD    = 4,
    parameter int STAGGER = 2,
    parameter int PC_W    = 32,
    parameter int WDOG    = 256,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             sw_rst_req,
    input  logic             wdog_en,
    input  logic [PC_W-1:0]  pc,
    output logic [NCH-1:0]   rst_n_out,
    output logic             seq_busy,
    output logic [1:0]       rst_cause,
    output logic [CNT_W-1:0] rst_count
);

    localparam int CMAX = (HOLD > STAGGER) ? HOLD : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idx;
    logic [NCH-1:0] rst_n_q;
    logic           sync_n;
    logic           in_run;
    logic           wdog_trig;
    logic           restart;
    logic           hold_done;
    logic           stag_done;
    logic           rel_now;
    logic           last_chan;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    reset_sync u_sync (
        .clk    (clk),
        .arst_n (clrn),
        .sync_n (sync_n)
    );

    assign in_run  = (state == S_RUN);
    assign restart = in_run && (sw_rst_req || wdog_trig);

    // Leaving SYNC already accounts for one hold cycle, since the synchroniser
    // released on the previous edge; HOLD == 1 therefore releases straight from SYNC.
    assign hold_done = ((state == S_SYNC) && sync_n && (HOLD == 1)) ||
                       ((state == S_HOLD) && (cnt + CW'(1) == CW'(HOLD)));
    assign stag_done = (state == S_REL) && (cnt + CW'(1) == CW'(STAGGER));
    assign rel_now   = hold_done || stag_done;
    assign last_chan = (idx == IW'(NCH - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_SYNC;
            cnt       <= '0;
            idx       <= '0;
            rst_n_q   <= '0;
            rst_cause <= CAUSE_POR;
            rst_count <= '0;
        end else if (restart) begin
            state     <= S_HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_n_q   <= '0;
            rst_cause <= sw_rst_req ? CAUSE_SW : CAUSE_WDOG;
            rst_count <= sat_inc(rst_count);
        end else if (rel_now) begin
            rst_n_q[idx] <= 1'b1;
            cnt          <= '0;
            if (last_chan) begin
                state <= S_RUN;
            end else begin
                state <= S_REL;
                idx   <= idx + IW'(1);
            end
        end else begin
            case (state)
                S_SYNC: begin
                    if (sync_n) begin
                        state <= S_HOLD;
                        cnt   <= CW'(1);
                    end
                end
                S_HOLD, S_REL: cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

    generate
        if (WDOG > 0) begin : g_wdog
            localparam int WW = $clog2(WDOG + 1);

            logic [PC_W-1:0] pc_prev;
            logic [WW-1:0]   wcnt;
            logic            stall;

            always_ff @(posedge clk) begin
                pc_prev <= pc;
            end

            assign stall     = in_run && wdog_en && (pc == pc_prev);
            assign wdog_trig = stall && (wcnt == WW'(WDOG - 1));

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    wcnt <= '0;
                end else if (stall && !restart) begin
                    wcnt <= wcnt + WW'(1);
                end else begin
                    wcnt <= '0;
                end
            end
        end else begin : g_no_wdog
            logic unused_wdog;
            assign unused_wdog = ^{wdog_en, pc};
            assign wdog_trig   = 1'b0;
        end
    endgenerate

    assign rst_n_out = rst_n_q;
    assign seq_busy  = ~(&rst_n_q);

endmodule

// File: doc/cpu_reset_seq.md
Name: cpu_reset_seq

Overview:
Parametrised, synthesizable reset sequencer for the pipelined CPU and its peripherals. It replaces hand-timed clrn pulses in benches with a deterministic on-chip sequence.
- Takes the board-level clrn and produces NCH staggered active-low channel resets.
- Supports software-requested re-reset and a PC-stall watchdog re-reset.
- Reports reset cause and a reset counter.
- Sits between the top-level clock/reset pins and the cpu core, memories and IO.

Parameters:
- NCH, 2, number of reset output channels (≥1); channel 0 is released first.
- HOLD, 4, cycles all channels stay asserted after the synchronised reset release or after a re-reset trigger (≥1).
- STAGGER, 2, cycles between release of channel k-1 and channel k (≥1).
- PC_W, 32, width of monitored program counter.
- WDOG, 256, consecutive cycles of unchanged pc that trigger a watchdog reset; 0 disables the watchdog logic entirely.
- CNT_W, 8, width of rst_count.

Ports:
- clk, input, 1, system clock.
- clrn, input, 1, asynchronous active-low reset.
- sw_rst_req, input, 1, single-cycle software reset request; honoured only when not busy.
- wdog_en, input, 1, watchdog enable.
- pc, input, PC_W, cpu program counter being monitored.
- rst_n_out, output, NCH, per-channel active-low resets.
- seq_busy, output, 1, high while any channel is asserted.
- rst_cause, output, 2, cause of last reset: 00 power-on/clrn, 01 software, 10 watchdog.
- rst_count, output, CNT_W, count of software plus watchdog resets; saturates at all-ones.

Behaviour:
- Reset is one clock, asynchronous and active-low: clrn low immediately forces the following, regardless of clk.
  - rst_n_out = 0, seq_busy = 1, rst_cause = 00, rst_count = 0.
  - Watchdog counter = 0, FSM = SYNC.
- clrn deassertion passes through a 2-flop synchroniser (async assert, sync release).
- FSM states:
  - SYNC: wait for the synchronised release, then go to HOLD with counter = 0.
  - HOLD: count HOLD cycles, then go to REL with idx = 0.
  - REL: release rst_n_out[idx], then wait STAGGER cycles per subsequent channel. After channel NCH-1 is released, go to RUN.
  - RUN: normal operation; seq_busy = 0.
- Timing from the first rising edge with clrn high:
  - rst_n_out[0] rises on edge 2+HOLD.
  - rst_n_out[k] rises on edge 2+HOLD+k*STAGGER.
  - seq_busy falls on the same edge as the last channel.
  - Defaults give edges 6 and 8.
- In RUN, a software reset (sw_rst_req high at an edge) has this effect on the next edge:
  - All rst_n_out go to 0 and seq_busy goes to 1.
  - rst_cause becomes 01 and rst_count increments.
  - FSM goes to HOLD with counter cleared, skipping SYNC.
- Watchdog:
  - Counter increments each RUN cycle when wdog_en = 1 and pc equals the previous-cycle pc.
  - Counter clears when pc changes, when wdog_en = 0, or when not in RUN.
  - When the counter reaches WDOG, the sequencer takes the same action as a software reset, but with rst_cause = 10.
- Priority:
  - sw_rst_req and a watchdog trigger in the same cycle: software wins, rst_cause = 01, count increments by 1 only.
  - sw_rst_req while seq_busy = 1 is ignored, with no count change.
- clrn low mid-sequence or mid-RUN aborts everything immediately and restarts from SYNC.
- rst_cause and rst_count hold their values across software and watchdog resets.
- rst_count at all-ones stays at all-ones.
- The pc history register is reloaded every cycle, so a pc equal to its pre-reset value is not counted while busy.

Decomposition:
- Package cpu_reset_pkg holds:
  - State enum {SYNC, HOLD, REL, RUN}.
  - Cause constants CAUSE_POR = 2'b00, CAUSE_SW = 2'b01, CAUSE_WDOG = 2'b10.
- One sub-module, reset_sync: 2-flop synchroniser with async assert and sync release.

Test Plan (defaults except WDOG = 16):
- Power-on: clrn low 3 cycles then high → rst_n_out = 00 until edge 6, = 01 at edge 6, = 11 at edge 8; seq_busy falls at edge 8; rst_cause = 00; rst_count = 0.
- Software reset: in RUN, pulse sw_rst_req one cycle → next edge rst_n_out = 00 and rst_cause = 01; rst_count = 1; channels re-release 4 and 6 edges later.
- Watchdog: wdog_en = 1, pc held at 0x0000_0040 → reset on the 16th stalled cycle with rst_cause = 10 and rst_count increments. With pc toggling every 10 cycles → no reset.
- Collision: sw_rst_req asserted on the same edge the watchdog reaches 16 → rst_cause = 01, rst_count +1. A sw_rst_req during HOLD → ignored.
- Async abort: clrn low for 2 ns mid-REL, between clock edges → outputs drop to 0 immediately, without waiting for an edge; rst_count = 0; sequence restarts with the 6/8-edge timing.
- Saturation (CNT_W = 2): four software resets → rst_count = 3 after both the 3rd and 4th resets.
